// File: rtl/dac_volt_out.sv
// dac_volt_out: mV setpoint -> 8-bit DAC code via a serial divider,
// slewed onto a parallel DAC clocked by a divided sample clock.
module dac_volt_out #(
   parameter int CLK_DIV   = 4,
   parameter int VREF_MV   = 5000,
   parameter int SLEW_STEP = 1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [12:0] volt_mv,
   input  logic        volt_vld,
   output logic        volt_rdy,
   output logic        busy,
   output logic        ovr,
   output logic        da_clk,
   output logic [7:0]  da_data
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
   localparam logic [12:0]   VREF     = 13'(VREF_MV);
   localparam logic [20:0]   HALF_REF = 21'(VREF_MV / 2);
   localparam logic [7:0]    STEP     = 8'(SLEW_STEP);

   typedef enum logic [1:0] {IDLE, CONV, RAMP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          tick;
   logic          accept;
   logic          over;
   logic [12:0]   v_clamp;
   logic [20:0]   num_init;
   logic [20:0]   num, num_nxt;
   logic [12:0]   rem, rem_nxt;
   logic [13:0]   trial;
   logic          q_bit;
   logic [4:0]    bit_cnt;
   logic [7:0]    target;
   logic          go_up;
   logic [7:0]    diff, step_amt, da_nxt;

   assign tick     = (cnt == CNT_MAX);
   assign cnt_nxt  = tick ? '0 : cnt + 1'b1;
   assign volt_rdy = (state == IDLE);
   assign busy     = ~volt_rdy;
   assign accept   = volt_rdy & volt_vld;
   assign over     = (volt_mv > VREF);
   assign v_clamp  = over ? VREF : volt_mv;
   // v*255 + VREF/2 cannot exceed 21 bits because v is clamped to VREF
   assign num_init = 21'(v_clamp) * 21'd255 + HALF_REF;

   // one restoring-division step: shift numerator MSB into remainder
   assign trial   = {rem, num[20]};
   assign q_bit   = (trial >= {1'b0, VREF});
   assign rem_nxt = q_bit ? 13'(trial - {1'b0, VREF}) : trial[12:0];
   assign num_nxt = {num[19:0], q_bit};

   // bounded step toward target, clipped so it never overshoots
   always_comb begin
      go_up    = (da_data < target);
      diff     = go_up ? target - da_data : da_data - target;
      step_amt = (diff < STEP) ? diff : STEP;
      da_nxt   = go_up ? da_data + step_amt : da_data - step_amt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (volt_vld) state_nxt = CONV;
         CONV:    if (bit_cnt == 5'd20) state_nxt = RAMP;
         RAMP:    if (da_data == target) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // sample clock: da_clk tracks cnt>=CLK_DIV/2, so it falls on tick
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt    <= '0;
         da_clk <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         da_clk <= (cnt_nxt >= CNT_HALF);
      end
   end

   // divider, target capture, overrange pulse and DAC code slewing
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         num     <= '0;
         rem     <= '0;
         bit_cnt <= '0;
         target  <= '0;
         ovr     <= 1'b0;
         da_data <= '0;
      end else begin
         ovr <= accept & over;
         if (accept) begin
            num     <= num_init;
            rem     <= '0;
            bit_cnt <= '0;
         end
         if (state == CONV) begin
            num     <= num_nxt;
            rem     <= rem_nxt;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd20) target <= num_nxt[7:0];
         end
         if (state == RAMP && tick && da_data != target)
            da_data <= da_nxt;
      end
   end

endmodule
